// File: rtl/xs3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xs3_pkg                                                    |
// | Purpose  : Shared types and constants for the serial BCD-to-XS3 core  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } xs3State_t;

    localparam logic [3:0] XS3_OFFSET   = 4'b0011;
    localparam int         DEFAULT_NDIG = 4;

endpackage : xs3_pkg
`default_nettype wire

// File: rtl/xs3_bit_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : xs3_bit_adder                                              |
// | Purpose  : Combinational 1-bit full adder for the serial datapath     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module xs3_bit_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : xs3_bit_adder
`default_nettype wire

// File: rtl/bcd_to_excess3_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_to_excess3_serial                                      |
// | Purpose  : Bit-serial BCD to Excess-3 converter with valid/ready I/O  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_to_excess3_serial
    import xs3_pkg::*;
#(
    parameter int NDIG = DEFAULT_NDIG
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   in_bcd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_xs3,
    output logic                out_err
);

    localparam int                c_width   = 4 * NDIG;
    localparam int                c_cntW    = $clog2(c_width);
    localparam logic [c_cntW-1:0] c_lastBit = c_cntW'(c_width - 1);

    xs3State_t           r_state;
    logic                r_inReady;
    logic                r_outValid;
    logic [c_width-1:0]  r_outXs3;
    logic                r_outErr;
    logic [c_width-1:0]  r_shift;
    logic [c_width-1:0]  r_result;
    logic [c_cntW-1:0]   r_cnt;
    logic                r_carry;
    logic                r_err;
    logic [1:0]          r_digit;

    logic [1:0]          w_pos;
    logic                w_bit;
    logic                w_addend;
    logic                w_sum;
    logic                w_cout;
    logic                w_digitBad;
    logic                w_errNext;

    assign w_pos    = r_cnt[1:0];
    assign w_bit    = r_shift[0];
    assign w_addend = XS3_OFFSET[w_pos];

    xs3_bit_adder u_adder (
        .a    (w_bit),
        .b    (w_addend),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // r_digit holds bits 2 and 1 of the current digit once bit 3 is on the wire
    assign w_digitBad = (w_pos == 2'd3) & w_bit & (r_digit[1] | r_digit[0]);
    assign w_errNext  = r_err | w_digitBad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outXs3   <= '0;
            r_outErr   <= 1'b0;
            r_shift    <= '0;
            r_result   <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_err      <= 1'b0;
            r_digit    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shift   <= in_bcd;
                        r_result  <= '0;
                        r_cnt     <= '0;
                        r_carry   <= 1'b0;
                        r_err     <= 1'b0;
                        r_digit   <= '0;
                        r_inReady <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shift  <= r_shift >> 1;
                    r_result <= {w_sum, r_result[c_width-1:1]};
                    r_digit  <= {w_bit, r_digit[1]};
                    // Carry out of a digit's MSB is dropped to give the mod-16 wrap
                    r_carry  <= (w_pos == 2'd3) ? 1'b0 : w_cout;
                    r_err    <= w_errNext;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_lastBit) begin
                        r_cnt      <= '0;
                        r_outXs3   <= {w_sum, r_result[c_width-1:1]};
                        r_outErr   <= w_errNext;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_outXs3   <= '0;
                        r_outErr   <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_inReady <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_xs3   = r_outXs3;
    assign out_err   = r_outErr;

endmodule : bcd_to_excess3_serial
`default_nettype wire

// File: tb/tb_bcd_to_excess3_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bcd_to_excess3_serial                                   |
// | Purpose  : Directed self-checking bench for bcd_to_excess3_serial     |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bcd_to_excess3_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_xs3;
    logic        out_err;

    int asserts  = 0;
    int failures = 0;

    bcd_to_excess3_serial #(.NDIG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_xs3   (out_xs3),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Drive one word, scramble in_bcd while shifting, return result and edges-to-valid
    task automatic send_word(input logic [15:0] bcd, output logic [15:0] xs3,
                             output logic err, output int lat);
        lat = -1;
        xs3 = '0;
        err = 1'b0;
        in_valid = 1'b1;
        in_bcd   = bcd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = ~bcd;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                lat = k - 1;
                break;
            end
            @(posedge clk); #1;
            in_bcd = in_bcd + 16'h1111;
        end
        if (lat < 0 && out_valid) lat = 40;
        xs3 = out_xs3;
        err = out_err;
    endtask

    task automatic release_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_bcd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        asserts++;
        if ({in_ready, out_valid, out_xs3, out_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b xs3=%h err=%b, want 1 0 0000 0",
                     in_ready, out_valid, out_xs3, out_err);
        end
    endtask

    task automatic test_convert(input logic [15:0] bcd, input logic [15:0] expXs3,
                                input logic expErr);
        logic [15:0] xs3;
        logic        err;
        int          lat;
        send_word(bcd, xs3, err, lat);
        asserts++;
        if (lat !== 16) begin
            failures++;
            $display("FAIL latency %h: got %0d edges, want 16", bcd, lat);
        end
        asserts++;
        if (xs3 !== expXs3) begin
            failures++;
            $display("FAIL xs3 %h: got %h, want %h", bcd, xs3, expXs3);
        end
        asserts++;
        if (err !== expErr) begin
            failures++;
            $display("FAIL err %h: got %b, want %b", bcd, err, expErr);
        end
        release_word();
        asserts++;
        if (out_valid !== 1'b0 || out_xs3 !== 16'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release %h: vld=%b xs3=%h rdy=%b, want 0 0000 1",
                     bcd, out_valid, out_xs3, in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] xs3;
        logic        err;
        int          lat;
        send_word(16'h1234, xs3, err, lat);
        asserts++;
        if (xs3 !== 16'h4567) begin
            failures++;
            $display("FAIL bp_first: got %h, want 4567", xs3);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_bcd = 16'h0101 * 16'(c + 1);
            @(posedge clk); #1;
            asserts++;
            if (out_valid !== 1'b1 || out_xs3 !== 16'h4567 || out_err !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: vld=%b xs3=%h err=%b rdy=%b, want 1 4567 0 0",
                         c, out_valid, out_xs3, out_err, in_ready);
            end
        end
        in_valid = 1'b0;
        release_word();
        asserts++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1;
        in_bcd   = 16'h9876;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        asserts++;
        if ({in_ready, out_valid, out_xs3, out_err} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
            failures++;
            $display("FAIL mid_rst: rdy=%b vld=%b xs3=%h err=%b, want 1 0 0000 0",
                     in_ready, out_valid, out_xs3, out_err);
        end
        test_convert(16'h0505, 16'h3838, 1'b0);
    endtask

    task automatic test_back_to_back();
        int accepts[3];
        int nAcc = 0;
        int nOut = 0;
        in_bcd    = 16'h2468;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && nAcc < 3; cyc++) begin
            if (in_ready && in_valid) begin
                accepts[nAcc] = cyc;
                nAcc++;
            end
            if (out_valid) begin
                nOut++;
                asserts++;
                if (out_xs3 !== 16'h579B || out_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data: xs3=%h err=%b, want 579b 0", out_xs3, out_err);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        asserts++;
        if (nAcc !== 3 || nOut < 2) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d outputs=%0d, want 3 and >=2", nAcc, nOut);
        end else begin
            for (int i = 1; i < 3; i++) begin
                asserts++;
                if (accepts[i] - accepts[i-1] !== 18) begin
                    failures++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 18",
                             i, accepts[i] - accepts[i-1]);
                end
            end
        end
        // Drain the word accepted on the final counted edge
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_convert(16'h0000, 16'h3333, 1'b0);
        test_convert(16'h1234, 16'h4567, 1'b0);
        test_convert(16'h9999, 16'hCCCC, 1'b0);
        test_convert(16'h12A4, 16'h45D7, 1'b1);
        test_convert(16'hF000, 16'h2333, 1'b1);
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule : tb_bcd_to_excess3_serial
`default_nettype wire
